// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges load-use,
// branch/jump redirect, data-memory wait and mul/div requests into per-stage
// enables and bubble controls. Also runs the mul/div go/ack handshake and
// keeps stall/flush event counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal flow; a mul/div op in EX issues md_go
//   ST_MD_WAIT | EX holds the mul/div op until md_done (or latched md_rdy)
module pipeline_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_stall,
    input  logic             branch_taken_ex,
    input  logic             jump_id,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_op_ex,
    input  logic             md_done,
    output logic             md_go,
    output logic             md_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       md_rdy;
    logic       md_rdy_nxt;
    logic       mem_wait;
    logic       md_hit;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign md_hit   = md_done | md_rdy;

    // Priority resolution of all stall/flush requests into stage controls.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        md_go        = 1'b0;
        md_ack       = 1'b0;
        state_nxt    = state;
        md_rdy_nxt   = md_rdy;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_nxt    = ST_RUN;
            md_rdy_nxt   = 1'b0;
        end else if (mem_wait) begin
            // Freeze everything up to EX/MEM; the load/store retires nothing.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            // A result landing now must not be lost while EX/MEM is frozen.
            if (md_done)
                md_rdy_nxt = 1'b1;
        end else if (state == ST_RUN && md_op_ex) begin
            md_go        = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            state_nxt    = ST_MD_WAIT;
        end else if (state == ST_MD_WAIT && !md_hit) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else begin
            if (state == ST_MD_WAIT) begin
                // Result captured into EX/MEM; ID/EX advances past the op.
                md_ack     = 1'b1;
                md_rdy_nxt = 1'b0;
                state_nxt  = ST_RUN;
            end
            if (state == ST_RUN && branch_taken_ex) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_stall) begin
                // Jump waits too: its operand may come from the load.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (jump_id) begin
                if_id_flush = 1'b1;
            end
        end
    end

    // FSM state and sticky mul/div-ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            md_rdy <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_rdy <= md_rdy_nxt;
        end
    end

    // Performance counters; wrap naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en)
                stall_count <= stall_count + 1'b1;
            if (if_id_flush)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_use_stall, branch_taken_ex, jump_id;
    logic        dmem_req, dmem_ready, md_op_ex, md_done;
    logic        md_go, md_ack;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
    logic [31:0] stall_count, flush_count;

    logic        md_go4, md_ack4, pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_flush4;
    logic        ex_mem_en4, ex_mem_flush4, mem_wb_en4, mem_wb_flush4;
    logic [3:0]  stall_count4, flush_count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
        .jump_id(jump_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .md_op_ex(md_op_ex), .md_done(md_done),
        .md_go(md_go), .md_ack(md_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
        .jump_id(jump_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .md_op_ex(md_op_ex), .md_done(md_done),
        .md_go(md_go4), .md_ack(md_ack4),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .if_id_flush(if_id_flush4),
        .id_ex_en(id_ex_en4), .id_ex_flush(id_ex_flush4),
        .ex_mem_en(ex_mem_en4), .ex_mem_flush(ex_mem_flush4),
        .mem_wb_en(mem_wb_en4), .mem_wb_flush(mem_wb_flush4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb}
    wire [4:0] en_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    // {if_id, id_ex, ex_mem, mem_wb}
    wire [3:0] fl_vec = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    wire [1:0] hs_vec = {md_go, md_ack};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_use_stall = 0; branch_taken_ex = 0; jump_id = 0;
        dmem_req = 0; dmem_ready = 0; md_op_ex = 0; md_done = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #1;
        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            chk("rst_en", en_vec, 5'b00000);
            chk("rst_flush", fl_vec, 4'b1111);
            chk("rst_hs", hs_vec, 2'b00);
            tick();
        end
        chk("rst_stall_cnt", stall_count, 0);
        chk("rst_flush_cnt", flush_count, 0);

        reset = 0;
        #1;
        chk("idle_en", en_vec, 5'b11111);
        chk("idle_flush", fl_vec, 4'b0000);
        chk("idle_hs", hs_vec, 2'b00);
        for (int i = 0; i < 10; i++) tick();
        chk("idle_stall_cnt", stall_count, 0);
        chk("idle_flush_cnt", flush_count, 0);

        // Load-use stall alone
        load_use_stall = 1;
        #1;
        chk("lu_en", en_vec, 5'b00111);
        chk("lu_flush", fl_vec, 4'b0100);
        tick();
        chk("lu_stall_cnt", stall_count, 1);

        // Load-use beats jump
        jump_id = 1;
        #1;
        chk("lu_jmp_en", en_vec, 5'b00111);
        chk("lu_jmp_flush", fl_vec, 4'b0100);
        tick();
        chk("lu_jmp_stall_cnt", stall_count, 2);
        chk("lu_jmp_flush_cnt", flush_count, 0);

        // Branch beats load-use and jump
        branch_taken_ex = 1;
        #1;
        chk("br_en", en_vec, 5'b11111);
        chk("br_flush", fl_vec, 4'b1100);
        tick();
        chk("br_stall_cnt", stall_count, 2);
        chk("br_flush_cnt", flush_count, 1);
        idle_inputs();

        // Jump alone
        jump_id = 1;
        #1;
        chk("jmp_flush", fl_vec, 4'b1000);
        chk("jmp_en", en_vec, 5'b11111);
        tick();
        chk("jmp_flush_cnt", flush_count, 2);
        idle_inputs();

        // Mul/div: go at cycle 0, done at cycle 5
        md_op_ex = 1;
        #1;
        chk("md0_hs", hs_vec, 2'b10);
        chk("md0_en", en_vec, 5'b00011);
        chk("md0_flush", fl_vec, 4'b0010);
        tick();
        for (int i = 1; i < 5; i++) begin
            chk("mdw_hs", hs_vec, 2'b00);
            chk("mdw_en", en_vec, 5'b00011);
            chk("mdw_flush", fl_vec, 4'b0010);
            tick();
        end
        md_done = 1;
        #1;
        chk("md5_hs", hs_vec, 2'b01);
        chk("md5_en", en_vec, 5'b11111);
        chk("md5_flush", fl_vec, 4'b0000);
        tick();
        idle_inputs();
        #1;
        chk("md_after_hs", hs_vec, 2'b00);
        chk("md_stall_cnt", stall_count, 7);
        chk("md_flush_cnt", flush_count, 2);

        // Mul/div with mem wait; md_done during the 2nd mem-wait cycle
        md_op_ex = 1;
        #1;
        chk("mm_go", hs_vec, 2'b10);
        tick();
        dmem_req = 1;
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            md_done = (i == 1);
            #1;
            chk("mm_wait_hs", hs_vec, 2'b00);
            chk("mm_wait_en", en_vec, 5'b00001);
            chk("mm_wait_flush", fl_vec, 4'b0001);
            tick();
        end
        md_done = 0;
        dmem_ready = 1;
        #1;
        chk("mm_ack_hs", hs_vec, 2'b01);
        chk("mm_ack_en", en_vec, 5'b11111);
        tick();
        idle_inputs();
        #1;
        chk("mm_after_hs", hs_vec, 2'b00);
        chk("mm_stall_cnt", stall_count, 11);

        // Reset in MD_WAIT: returns to RUN with no stale ready
        md_op_ex = 1;
        #1;
        tick();
        reset = 1;
        tick();
        reset = 0;
        md_op_ex = 0;
        #1;
        chk("rstmd_hs", hs_vec, 2'b00);
        chk("rstmd_en", en_vec, 5'b11111);
        chk("rstmd_stall_cnt", stall_count, 0);

        // Counter wrap on the 4-bit instance
        load_use_stall = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("wrap4_15", {28'd0, stall_count4}, 15);
        tick();
        chk("wrap4_0", {28'd0, stall_count4}, 0);
        chk("wrap32_16", stall_count, 16);
        idle_inputs();
        tick();
        chk("wrap4_hold", {28'd0, stall_count4}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines these requests into per-stage register enables and bubble/flush controls:
  - load-use stall from the hazard/forwarding unit;
  - EX-stage branch redirect;
  - ID-stage jump redirect;
  - multi-cycle data-memory wait;
  - multi-cycle mul/div unit.
- Owns the mul/div start/acknowledge handshake and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of stall_count and flush_count (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
load_use_stall  in  1  load-use hazard on IF/ID instruction
branch_taken_ex  in  1  branch/JALR in EX resolved taken; PC mux selects target
jump_id  in  1  JAL resolved in ID; PC mux selects target
dmem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
md_op_ex  in  1  EX-stage instruction is mul/div
md_done  in  1  one-cycle pulse; mul/div result valid, held stable until md_ack
md_go  out  1  one-cycle start pulse to mul/div unit
md_ack  out  1  one-cycle pulse; mul/div result captured into EX/MEM
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_en  out  1  EX/MEM load enable
ex_mem_flush  out  1  EX/MEM loads bubble
mem_wb_en  out  1  MEM/WB load enable
mem_wb_flush  out  1  MEM/WB loads bubble
stall_count  out  CNT_W  cycles with pc_en=0 since reset
flush_count  out  CNT_W  cycles with if_id_flush=1 since reset

Behaviour:
- Flush has effect only when the matching _en=1. Outputs are combinational from state and inputs, zero latency.
- Registered state:
  - FSM {RUN, MD_WAIT};
  - md_rdy sticky flag;
  - the two counters.
- Reset (synchronous): state=RUN, md_rdy=0, counters=0. While reset=1: all _en=0, all _flush=1, md_go=0, md_ack=0, counters do not increment.
- Default (nothing asserted): all _en=1, all _flush=0.
- Cycle priority, highest first:
  - P1 mem wait (dmem_req & ~dmem_ready):
    - pc_en=if_id_en=id_ex_en=ex_mem_en=0;
    - mem_wb_en=1, mem_wb_flush=1;
    - md_go=md_ack=0;
    - state unchanged; md_done still sets md_rdy.
  - P2 RUN & md_op_ex:
    - md_go=1, next state MD_WAIT;
    - pc/if_id/id_ex enables=0;
    - ex_mem_en=1 with ex_mem_flush=1; mem_wb normal.
  - P3 MD_WAIT & ~(md_done|md_rdy):
    - same hold/bubble as P2, md_go=0.
  - P4 MD_WAIT & (md_done|md_rdy):
    - md_ack=1, ex_mem_en=1 (captures result), md_rdy cleared, next state RUN;
    - front end then follows P6/P7/default.
  - P5 branch_taken_ex (RUN only):
    - pc_en=1;
    - if_id_flush=1, id_ex_flush=1;
    - overrides load_use_stall and jump_id.
  - P6 load_use_stall:
    - pc_en=0, if_id_en=0, id_ex_flush=1;
    - overrides jump_id (jump operand not yet available).
  - P7 jump_id:
    - pc_en=1, if_id_flush=1.
- md_go fires exactly once per mul/div instruction. The first cycle back in RUN always sees a new EX instruction, because ID/EX advanced on the md_ack cycle.
- md_done arriving during P1 is latched in md_rdy. It is consumed on the first cycle without mem wait.
- Counter updates:
  - stall_count += 1 every non-reset cycle with pc_en=0;
  - flush_count += 1 every non-reset cycle with if_id_flush=1;
  - both wrap to 0 at all-ones.
- Reset asserted mid-MD_WAIT returns to RUN with md_rdy=0. The mul/div unit is reset by the same signal.

Test Plan:
- Reset held 3 cycles, then idle → during reset all _en=0 and _flush=1. After release all _en=1, _flush=0, counters 0; after 10 idle cycles counters still 0.
- load_use_stall=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_count=1. Same cycle with jump_id=1 → if_id_flush=0, flush_count unchanged.
- branch_taken_ex=1 with load_use_stall=1 → pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count +1, stall_count unchanged.
- md_op_ex=1, md_done 5 cycles later:
  - md_go pulse in cycle 0 only;
  - cycles 0-4: pc_en=0, ex_mem_flush=1;
  - cycle 5: md_ack=1, ex_mem_en=1, pc_en=1;
  - stall_count=5.
- MD_WAIT with dmem_req=1, dmem_ready=0 for 3 cycles and md_done during the 2nd:
  - md_ack stays 0 while mem wait persists, mem_wb_flush=1;
  - md_ack=1 on the first cycle dmem_ready=1.
- Force stall_count to all-ones via CNT_W=4 build and 16 stalled cycles → count wraps to 0, no X.
